// File: rtl/result_frame_sequencer_if.sv
// Bundle between the measurement controller / UART TX side (master) and the
// frame sequencer (slave).
interface result_frame_sequencer_if #(
  parameter int CNT_W = 32
);
  // Handshakes: start is a one-cycle request taken only while busy is low;
  // tx_start is held with tx_data stable until tx_busy is seen high at a clock edge.
  logic             start;
  logic             busy;
  logic [1:0]       mode;
  logic [CNT_W-1:0] f_count;
  logic [CNT_W-1:0] t_count;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             frame_done;

  modport master (
    output start, mode, f_count, t_count, tx_busy,
    input  busy, tx_data, tx_start, frame_done
  );

  modport slave (
    input  start, mode, f_count, t_count, tx_busy,
    output busy, tx_data, tx_start, frame_done
  );
endinterface

// File: rtl/result_frame_sequencer.sv
// Serialises one latched measurement result into a HEADER/mode/counts/XOR frame
// and feeds it byte by byte to the UART transmitter.
module result_frame_sequencer #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  result_frame_sequencer_if.slave   bus,
  output logic [2:0]                dbg_state
);

  localparam int NB        = CNT_W / 8;
  localparam int FRAME_MAX = 3 + 2 * NB;
  localparam int IDX_W     = $clog2(FRAME_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] f_q, f_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic             busy_q, busy_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_done_q, frame_done_d;

  // Index of the checksum byte, i.e. the last byte of the frame.
  function automatic int last_idx(input logic [1:0] m);
    int nf;
    int nt;
    nf = m[1] ? NB : 0;
    nt = m[0] ? NB : 0;
    return 2 + nf + nt;
  endfunction

  // Byte at position idx; the checksum slot returns the running XOR, which
  // already covers every earlier byte by the time that slot is presented.
  function automatic logic [7:0] byte_at(
    input logic [IDX_W-1:0] idx,
    input logic [1:0]       m,
    input logic [CNT_W-1:0] f,
    input logic [CNT_W-1:0] t,
    input logic [7:0]       cs
  );
    int i;
    int nf;
    int nt;
    logic [7:0] b;
    i  = int'(idx);
    nf = m[1] ? NB : 0;
    nt = m[0] ? NB : 0;
    b  = cs;
    if (i == 0) begin
      b = HEADER;
    end else if (i == 1) begin
      b = {6'b0, m};
    end else if (i < 2 + nf) begin
      b = 8'(f >> (8 * (NB - 1 - (i - 2))));
    end else if (i < 2 + nf + nt) begin
      b = 8'(t >> (8 * (NB - 1 - (i - 2 - nf))));
    end
    return b;
  endfunction

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    f_d          = f_q;
    t_d          = t_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    busy_d       = busy_q;
    tx_start_d   = tx_start_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          f_d     = bus.f_count;
          t_d     = bus.t_count;
          csum_d  = 8'h00;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SYNC;
        end
      end
      // A UART still busy from an earlier user must not be read as acceptance.
      S_SYNC: begin
        if (!bus.tx_busy) begin
          tx_data_d  = byte_at(idx_q, mode_q, f_q, t_q, csum_q);
          tx_start_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.tx_busy) begin
          csum_d     = csum_q ^ tx_data_q;
          tx_start_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (int'(idx_q) != last_idx(mode_q)) begin
            idx_d      = idx_q + IDX_W'(1);
            tx_data_d  = byte_at(idx_d, mode_q, f_q, t_q, csum_q);
            tx_start_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      f_q          <= '0;
      t_q          <= '0;
      idx_q        <= '0;
      csum_q       <= 8'h00;
      busy_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      f_q          <= f_d;
      t_q          <= t_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      busy_q       <= busy_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.frame_done = frame_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_result_frame_sequencer.sv
// Directed bench for result_frame_sequencer with a behavioural UART responder.
module tb_result_frame_sequencer;
  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_frame_sequencer_if #(.CNT_W(CNT_W)) bus ();

  result_frame_sequencer #(.HEADER(8'hA5), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // UART responder: accepts after accept_delay cycles, then stays busy busy_len cycles.
  int busy_len     = 10;
  int accept_delay = 0;
  int linger       = 0;
  int uart_cnt     = 0;
  int wait_cnt     = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_busy = 1'b0;
      uart_cnt    = 0;
      wait_cnt    = 0;
      linger      = 0;
    end else if (linger > 0) begin
      bus.tx_busy = 1'b1;
      linger      = linger - 1;
    end else if (uart_cnt > 0) begin
      uart_cnt    = uart_cnt - 1;
      bus.tx_busy = (uart_cnt != 0);
    end else if (bus.tx_start === 1'b1) begin
      if (wait_cnt < accept_delay) begin
        wait_cnt    = wait_cnt + 1;
        bus.tx_busy = 1'b0;
      end else begin
        wait_cnt    = 0;
        bus.tx_busy = 1'b1;
        uart_cnt    = busy_len;
        got_q.push_back(bus.tx_data);
      end
    end else begin
      bus.tx_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [31:0] f, input logic [31:0] t);
    @(negedge clk);
    bus.mode    = m;
    bus.f_count = f;
    bus.t_count = t;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    logic busy_ok = 1'b1;
    while (bus.frame_done !== 1'b1 && n < 2000) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(bus.frame_done), 64'd1);
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.frame_done), 64'd0);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   n;
    logic flag;
    bus.start   = 1'b0;
    bus.mode    = 2'b00;
    bus.f_count = '0;
    bus.t_count = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_tx_start", 64'(bus.tx_start), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 64'(dbg_state), 64'd0);

    // f_count only
    exp_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA3};
    start_frame(2'b10, 32'h01020304, 32'hFFFFFFFF);
    wait_done("t1");
    check_frame("t1");

    // both counts
    exp_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA6};
    start_frame(2'b11, 32'h00000001, 32'h00000100);
    wait_done("t2");
    check_frame("t2");

    // empty payload, no fourth byte afterwards
    exp_q = '{8'hA5, 8'h00, 8'hA5};
    start_frame(2'b00, 32'h12345678, 32'h9ABCDEF0);
    wait_done("t3");
    check_frame("t3");
    flag = 1'b1;
    repeat (6) begin
      if (bus.tx_start !== 1'b0) flag = 1'b0;
      @(negedge clk);
    end
    check("t3_no_extra_tx_start", 64'(flag), 64'd1);
    check("t3_no_extra_byte", 64'(got_q.size()), 64'd0);

    // lingering UART busy, restart pulse mid-frame, counts changed after start
    linger = 20;
    @(negedge clk);
    exp_q = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h85};
    start_frame(2'b10, 32'hDEADBEEF, 32'h0);
    bus.f_count = 32'h00000000;
    bus.mode    = 2'b01;
    flag = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.start = (i == 5);
      if (bus.tx_start !== 1'b0 || got_q.size() != 0) flag = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("t4_no_early_tx_start", 64'(flag), 64'd1);
    wait_done("t4");
    check_frame("t4");

    // slow acceptance: request must stay stable
    accept_delay = 7;
    exp_q = '{8'hA5, 8'h00, 8'hA5};
    start_frame(2'b00, 32'h0, 32'h0);
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_tx_start_seen", 64'(bus.tx_start), 64'd1);
    flag = 1'b1;
    repeat (7) begin
      if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) flag = 1'b0;
      @(negedge clk);
    end
    check("t5_request_stable", 64'(flag), 64'd1);
    wait_done("t5");
    check_frame("t5");
    accept_delay = 0;

    // reset while the fourth byte is being requested
    start_frame(2'b10, 32'h01020304, 32'h0);
    n = 0;
    while (!(got_q.size() == 3 && bus.tx_start === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_fourth_byte_req", 64'(bus.tx_start), 64'd1);
    check("t6_fourth_byte_val", 64'(bus.tx_data), 64'h02);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_start", 64'(bus.tx_start), 64'd0);
    check("t6_rst_busy", 64'(bus.busy), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    exp_q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE0};
    start_frame(2'b01, 32'hCAFEF00D, 32'h11223344);
    wait_done("t6");
    check_frame("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
